// File: rtl/div_act_pipe.sv
// div_act_pipe: two-stage valid/ready activation-derivative unit, LANES lanes, saturating, sticky ovf
// Ports: clk, rst (async, active-low) | i_valid/i_ready/i_mode/i_data input beat
//        o_valid/o_ready/o_data output beat | ovf sticky saturation flag, ovf_clr sync clear
module div_act_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [1:0]             i_mode,
  input  logic [LANES*WIDTH-1:0] i_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [LANES*WIDTH-1:0] o_data,
  output logic                   ovf,
  input  logic                   ovf_clr
);
  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;
  localparam logic signed [PW-1:0] ONE2 = PW'(1) << FRAC;
  logic s1_valid, s1_adv, s2_adv;
  logic [1:0] s1_mode;
  logic [LANES*WIDTH-1:0] s1_a, s1_b, b_in, r_all;
  logic [LANES-1:0] sat;
  assign s2_adv  = !o_valid || o_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign i_ready = s1_adv;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [WIDTH-1:0] a, b;
    logic signed [PW-1:0] p, q, r;
    assign b_in[k*WIDTH +: WIDTH] = i_mode == 2'b00 ? ONE - i_data[k*WIDTH +: WIDTH] : i_data[k*WIDTH +: WIDTH];
    assign a = s1_a[k*WIDTH +: WIDTH];
    assign b = s1_b[k*WIDTH +: WIDTH];
    assign p = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign q = p >>> FRAC;
    assign r = s1_mode == 2'b00 ? q :
               s1_mode == 2'b01 ? ONE2 - q :
               (s1_mode == 2'b10 && a <= 0) ? '0 : ONE2;
    // result fits in WIDTH only when the top WIDTH+1 bits are all sign copies
    assign sat[k] = !(&r[PW-1:WIDTH-1] || !(|r[PW-1:WIDTH-1]));
    assign r_all[k*WIDTH +: WIDTH] = sat[k] ? {r[PW-1], {(WIDTH-1){!r[PW-1]}}} : r[WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      ovf      <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= i_valid;
      if (s1_adv && i_valid) begin
        s1_mode <= i_mode;
        s1_a    <= i_data;
        s1_b    <= b_in;
      end
      if (s2_adv) o_valid <= s1_valid;
      if (s2_adv && s1_valid) o_data <= r_all;
      ovf <= (ovf && !ovf_clr) || (s2_adv && s1_valid && |sat);
    end
  end
endmodule
